sprite_mover_gen: RTL and testbench

- Parametrised successor to the single-sprite movement FSM.
- Accepts rate-limited diagonal move requests and computes a candidate position with parametrised step size and screen bounds.
- Delegates walkability to an external path-checker through a req/ack handshake, which replaces the hard-coded geometry.
- Sequences erase-background / update / draw-character with the sprite drawer, and supports a one-shot vertical lift (pillar), teleport and hide-on-finish.

---
 rtl/sprite_mover_gen.sv | 205 ++++++++++++++++++++
 tb/tb_sprite_mover_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover_gen.sv
// sprite_mover_gen: rate-limited diagonal sprite mover.
// A move is accepted on a tick. A candidate position is sent to an external
// path checker through a req/ack handshake. On acceptance the sprite is moved
// with an erase / update / draw sequence through the sprite drawer.
// One-shot lift, teleport and hide are also supported.
// Optional: define MOVE_BUFFER_EN for a 1-entry buffer of move requests made while busy.
module sprite_mover_gen #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int INIT_X   = 95,
  parameter int INIT_Y   = 221,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 6250000
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           move,
  input  logic [2:0]     dir,
  output logic           chk_req,
  output logic [X_W-1:0] chk_x,
  output logic [Y_W-1:0] chk_y,
  input  logic           chk_ack,
  input  logic           chk_ok,
  input  logic           chk_tele,
  input  logic [X_W-1:0] tele_x,
  input  logic [Y_W-1:0] tele_y,
  input  logic           lift,
  input  logic [Y_W-1:0] lift_dy,
  input  logic           hide,
  output logic           draw_bg,
  input  logic           done_bg,
  output logic           draw_char,
  input  logic           done_char,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           busy
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W:0]     STEP_X    = (X_W+1)'(STEP);
  localparam logic [Y_W:0]     STEP_Y    = (Y_W+1)'(STEP);
  localparam logic [X_W:0]     BOUND_X   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]     BOUND_Y   = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0]   HIDE_X    = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0]   HIDE_Y    = Y_W'(SCREEN_H);
  localparam logic [X_W-1:0]   RST_X     = X_W'(INIT_X);
  localparam logic [Y_W-1:0]   RST_Y     = Y_W'(INIT_Y);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ERASE, S_ERASE_WAIT, S_UPDATE, S_DRAW, S_DRAW_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       eff_dir;
  logic             start;
  logic [X_W:0]     cand_x;
  logic [Y_W:0]     cand_y;
  logic             cand_oob;
  logic             chk_oob;
  logic             tele_f;
  logic [X_W-1:0]   tele_xq;
  logic [Y_W-1:0]   tele_yq;
  logic             lift_done;
  logic             lift_pend;
  logic [Y_W-1:0]   lift_dyq;
  logic [Y_W-1:0]   lift_amt;
  logic [Y_W-1:0]   lifted_y;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running move-rate divider
  always_ff @(posedge clock) begin
    if (!resetn || tick) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef MOVE_BUFFER_EN
  logic       buf_valid;
  logic [1:0] buf_dir;

  // A buffered request takes precedence over the live inputs and ignores tick
  assign eff_dir = buf_valid ? buf_dir : dir[1:0];
  assign start   = !hide && (buf_valid || (move && tick && dir[2]));

  // Hold the newest request made while busy; emptied when consumed in IDLE
  always_ff @(posedge clock) begin
    if (!resetn || hide) begin
      buf_valid <= 1'b0;
      buf_dir   <= '0;
    end else if (state != S_IDLE && move && tick && dir[2]) begin
      buf_valid <= 1'b1;
      buf_dir   <= dir[1:0];
    end else if (state == S_IDLE && buf_valid) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign eff_dir = dir[1:0];
  assign start   = move && tick && dir[2] && !hide;
`endif

  // Candidate position and bounds test. The extra top bit catches underflow.
  always_comb begin
    cand_x   = eff_dir[0] ? ({1'b0, x} - STEP_X) : ({1'b0, x} + STEP_X);
    cand_y   = eff_dir[1] ? ({1'b0, y} - STEP_Y) : ({1'b0, y} + STEP_Y);
    cand_oob = (cand_x == '0) || cand_x[X_W] || (cand_x >= BOUND_X) ||
               (cand_y == '0) || cand_y[Y_W] || (cand_y >= BOUND_Y);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (start) state_nxt = S_CHECK;
      S_CHECK: begin
        if (chk_oob)      state_nxt = S_IDLE;
        else if (chk_ack) state_nxt = chk_ok ? S_ERASE : S_IDLE;
      end
      S_ERASE:      state_nxt = S_ERASE_WAIT;
      S_ERASE_WAIT: if (done_bg) state_nxt = S_UPDATE;
      S_UPDATE:     state_nxt = S_DRAW;
      S_DRAW:       state_nxt = S_DRAW_WAIT;
      S_DRAW_WAIT:  if (done_char) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Outputs; request lines are also gated by reset so they drop immediately
  always_comb begin
    busy      = (state != S_IDLE);
    chk_req   = resetn && (state == S_CHECK) && !chk_oob;
    draw_bg   = resetn && ((state == S_ERASE) || (state == S_ERASE_WAIT));
    draw_char = resetn && ((state == S_DRAW)  || (state == S_DRAW_WAIT));
  end

  // Capture the candidate on leaving IDLE and the checker result on acceptance
  always_ff @(posedge clock) begin
    if (!resetn) begin
      chk_x   <= '0;
      chk_y   <= '0;
      chk_oob <= 1'b0;
      tele_f  <= 1'b0;
      tele_xq <= '0;
      tele_yq <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        chk_x   <= cand_x[X_W-1:0];
        chk_y   <= cand_y[Y_W-1:0];
        chk_oob <= cand_oob;
      end
      if (state == S_CHECK && !chk_oob && chk_ack && chk_ok) begin
        tele_f  <= chk_tele;
        tele_xq <= tele_x;
        tele_yq <= tele_y;
      end else if (state == S_UPDATE) begin
        tele_f  <= 1'b0;
      end
    end
  end

  // Saturating lift; a lift that collides with UPDATE is replayed one cycle later
  always_comb begin
    lift_amt = lift_pend ? lift_dyq : lift_dy;
    lifted_y = (y >= lift_amt) ? (y - lift_amt) : '0;
  end

  // Sprite position: hide overrides UPDATE, UPDATE overrides lift
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x         <= RST_X;
      y         <= RST_Y;
      lift_done <= 1'b0;
      lift_pend <= 1'b0;
      lift_dyq  <= '0;
    end else begin
      if (hide) begin
        x <= HIDE_X;
        y <= HIDE_Y;
      end else if (state == S_UPDATE) begin
        x <= tele_f ? tele_xq : chk_x;
        y <= tele_f ? tele_yq : chk_y;
      end else if (lift_pend || (lift && !lift_done)) begin
        y <= lifted_y;
      end
      if (lift && !lift_done) begin
        lift_done <= 1'b1;
        lift_dyq  <= lift_dy;
      end
      lift_pend <= lift && !lift_done && (state == S_UPDATE);
    end
  end

endmodule

// File: tb/tb_sprite_mover_gen.sv
// Directed testbench for sprite_mover_gen (TICK_DIV=4, other parameters default).
module tb_sprite_mover_gen;

  logic       clock = 1'b0;
  logic       resetn;
  logic       move;
  logic [2:0] dir;
  logic       chk_req;
  logic [8:0] chk_x;
  logic [7:0] chk_y;
  logic       chk_ack, chk_ok, chk_tele;
  logic [8:0] tele_x;
  logic [7:0] tele_y;
  logic       lift;
  logic [7:0] lift_dy;
  logic       hide;
  logic       draw_bg, done_bg, draw_char, done_char;
  logic [8:0] x;
  logic [7:0] y;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] tb_cnt;

  sprite_mover_gen #(.TICK_DIV(4)) dut (
    .clock(clock), .resetn(resetn), .move(move), .dir(dir),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
    .chk_ack(chk_ack), .chk_ok(chk_ok), .chk_tele(chk_tele),
    .tele_x(tele_x), .tele_y(tele_y), .lift(lift), .lift_dy(lift_dy),
    .hide(hide), .draw_bg(draw_bg), .done_bg(done_bg),
    .draw_char(draw_char), .done_char(done_char),
    .x(x), .y(y), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference tick phase: tick is high while tb_cnt == 3
  always @(posedge clock) begin
    if (!resetn) tb_cnt <= 2'd0;
    else         tb_cnt <= tb_cnt + 2'd1;
  end

  task automatic do_reset();
    resetn = 1'b0; move = 1'b0; dir = 3'b000;
    chk_ack = 1'b0; chk_ok = 1'b0; chk_tele = 1'b0; tele_x = '0; tele_y = '0;
    lift = 1'b0; lift_dy = '0; hide = 1'b0; done_bg = 1'b0; done_char = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // Caller has set move/dir at a negedge; returns at the first negedge with busy=1
  task automatic wait_start(output bit started);
    bit prev_tick;
    started = 1'b0;
    for (int i = 0; i < 12; i++) begin
      prev_tick = (tb_cnt == 2'd3);
      @(negedge clock);
      if (busy) begin
        started = 1'b1;
        n_checks++;
        if (prev_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL start_on_tick: busy rose with tick=%0b, expected tick=1", prev_tick);
        end
        break;
      end
    end
    if (!started) begin
      n_checks++; n_fail++;
      $display("FAIL start_timeout: busy=%0b after 12 cycles, expected 1", busy);
    end
  endtask

  // Full move: checker answers after 2 cycles, drawer after 4
  task automatic run_seq(input logic [2:0] d, input bit ok, input bit tl,
                         input logic [8:0] tx, input logic [7:0] ty,
                         input logic [8:0] cx, input logic [7:0] cy,
                         input logic [8:0] ux, input logic [7:0] uy,
                         input logic [7:0] fy,
                         input bit lift_upd, input bit hide_dw, input bit move_er);
    bit st;
    move = 1'b1; dir = d;
    wait_start(st);
    move = 1'b0;
    if (!st) return;
    n_checks++;
    if (chk_req !== 1'b1 || chk_x !== cx || chk_y !== cy) begin
      n_fail++;
      $display("FAIL chk_cand: req=%0b x=%0d y=%0d, expected req=1 x=%0d y=%0d", chk_req, chk_x, chk_y, cx, cy);
    end
    repeat (2) @(negedge clock);
    n_checks++;
    if (chk_req !== 1'b1 || chk_x !== cx || chk_y !== cy) begin
      n_fail++;
      $display("FAIL chk_hold: req=%0b x=%0d y=%0d, expected req=1 x=%0d y=%0d", chk_req, chk_x, chk_y, cx, cy);
    end
    chk_ack = 1'b1; chk_ok = ok; chk_tele = tl; tele_x = tx; tele_y = ty;
    @(negedge clock);
    chk_ack = 1'b0; chk_ok = 1'b0; chk_tele = 1'b0;
    if (!ok) begin
      n_checks++;
      if (busy !== 1'b0 || draw_bg !== 1'b0 || x !== ux || y !== uy) begin
        n_fail++;
        $display("FAIL reject_idle: busy=%0b draw_bg=%0b x=%0d y=%0d, expected 0 0 %0d %0d", busy, draw_bg, x, y, ux, uy);
      end
      return;
    end
    n_checks++;
    if (draw_bg !== 1'b1 || draw_char !== 1'b0) begin
      n_fail++;
      $display("FAIL erase_req: draw_bg=%0b draw_char=%0b, expected 1 0", draw_bg, draw_char);
    end
    if (move_er) begin move = 1'b1; dir = 3'b110; end
    repeat (4) @(negedge clock);
    move = 1'b0;
    n_checks++;
    if (draw_bg !== 1'b1) begin
      n_fail++;
      $display("FAIL erase_hold: draw_bg=%0b, expected 1", draw_bg);
    end
    done_bg = 1'b1;
    @(negedge clock);
    done_bg = 1'b0;
    n_checks++;
    if (draw_bg !== 1'b0 || draw_char !== 1'b0) begin
      n_fail++;
      $display("FAIL update_quiet: draw_bg=%0b draw_char=%0b, expected 0 0", draw_bg, draw_char);
    end
    if (lift_upd) begin lift = 1'b1; lift_dy = 8'd74; end
    @(negedge clock);
    lift = 1'b0;
    n_checks++;
    if (x !== ux || y !== uy || draw_char !== 1'b1) begin
      n_fail++;
      $display("FAIL draw_pos: x=%0d y=%0d draw_char=%0b, expected %0d %0d 1", x, y, draw_char, ux, uy);
    end
    @(negedge clock);
    n_checks++;
    if (y !== fy) begin
      n_fail++;
      $display("FAIL post_draw_y: y=%0d, expected %0d", y, fy);
    end
    if (hide_dw) hide = 1'b1;
    @(negedge clock);
    if (hide_dw) begin
      n_checks++;
      if (x !== 9'd320 || y !== 8'd240 || draw_char !== 1'b1) begin
        n_fail++;
        $display("FAIL hide_force: x=%0d y=%0d draw_char=%0b, expected 320 240 1", x, y, draw_char);
      end
    end
    done_char = 1'b1;
    @(negedge clock);
    done_char = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || draw_char !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_done: busy=%0b draw_char=%0b, expected 0 0", busy, draw_char);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (x !== 9'd95 || y !== 8'd221) begin
      n_fail++;
      $display("FAIL reset_pos: x=%0d y=%0d, expected 95 221", x, y);
    end
    n_checks++;
    if (busy !== 1'b0 || chk_req !== 1'b0 || draw_bg !== 1'b0 || draw_char !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: busy=%0b req=%0b bg=%0b ch=%0b, expected all 0", busy, chk_req, draw_bg, draw_char);
    end
  endtask

  task automatic test_move();
    do_reset();
    run_seq(3'b110, 1'b1, 1'b0, 9'd0, 8'd0, 9'd96, 8'd220, 9'd96, 8'd220, 8'd220, 1'b0, 1'b0, 1'b0);
    run_seq(3'b110, 1'b1, 1'b0, 9'd0, 8'd0, 9'd97, 8'd219, 9'd97, 8'd219, 8'd219, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_oob();
    logic [8:0] mx;
    logic [7:0] my, ny;
    logic [2:0] d;
    bit st;
    do_reset();
    mx = 9'd95; my = 8'd221;
    for (int i = 0; i < 94; i++) begin
      d  = (i % 2 == 0) ? 3'b111 : 3'b101;
      ny = (i % 2 == 0) ? my - 8'd1 : my + 8'd1;
      run_seq(d, 1'b1, 1'b0, 9'd0, 8'd0, mx - 9'd1, ny, mx - 9'd1, ny, ny, 1'b0, 1'b0, 1'b0);
      mx = mx - 9'd1; my = ny;
    end
    n_checks++;
    if (x !== 9'd1 || y !== 8'd221) begin
      n_fail++;
      $display("FAIL oob_setup: x=%0d y=%0d, expected 1 221", x, y);
    end
    move = 1'b1; dir = 3'b101;
    wait_start(st);
    move = 1'b0;
    n_checks++;
    if (chk_req !== 1'b0) begin
      n_fail++;
      $display("FAIL oob_no_req: chk_req=%0b, expected 0", chk_req);
    end
    chk_ack = 1'b1; chk_ok = 1'b1;
    @(negedge clock);
    chk_ack = 1'b0; chk_ok = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || draw_bg !== 1'b0 || x !== 9'd1 || y !== 8'd221) begin
      n_fail++;
      $display("FAIL oob_idle: busy=%0b bg=%0b x=%0d y=%0d, expected 0 0 1 221", busy, draw_bg, x, y);
    end
  endtask

  task automatic test_reject_tele();
    do_reset();
    run_seq(3'b100, 1'b0, 1'b0, 9'd0, 8'd0, 9'd96, 8'd222, 9'd95, 8'd221, 8'd221, 1'b0, 1'b0, 1'b0);
    run_seq(3'b100, 1'b1, 1'b1, 9'd126, 8'd68, 9'd96, 8'd222, 9'd126, 8'd68, 8'd68, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lift();
    do_reset();
    lift = 1'b1; lift_dy = 8'd74;
    @(negedge clock);
    lift = 1'b0;
    n_checks++;
    if (y !== 8'd147) begin
      n_fail++;
      $display("FAIL lift_first: y=%0d, expected 147", y);
    end
    lift = 1'b1;
    @(negedge clock);
    lift = 1'b0;
    @(negedge clock);
    n_checks++;
    if (y !== 8'd147) begin
      n_fail++;
      $display("FAIL lift_second: y=%0d, expected 147", y);
    end
    do_reset();
    run_seq(3'b110, 1'b1, 1'b0, 9'd0, 8'd0, 9'd96, 8'd220, 9'd96, 8'd220, 8'd146, 1'b1, 1'b0, 1'b0);
    do_reset();
    run_seq(3'b100, 1'b1, 1'b1, 9'd126, 8'd100, 9'd96, 8'd222, 9'd126, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0);
    lift = 1'b1; lift_dy = 8'd250;
    @(negedge clock);
    lift = 1'b0;
    n_checks++;
    if (y !== 8'd0 || x !== 9'd126) begin
      n_fail++;
      $display("FAIL lift_sat: x=%0d y=%0d, expected 126 0", x, y);
    end
  endtask

  task automatic test_hide();
    int busy_cycles;
    do_reset();
    run_seq(3'b110, 1'b1, 1'b0, 9'd0, 8'd0, 9'd96, 8'd220, 9'd96, 8'd220, 8'd220, 1'b0, 1'b1, 1'b0);
    busy_cycles = 0;
    move = 1'b1; dir = 3'b110;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
    end
    move = 1'b0;
    n_checks++;
    if (busy_cycles !== 0 || x !== 9'd320 || y !== 8'd240) begin
      n_fail++;
      $display("FAIL hide_block: busy_cycles=%0d x=%0d y=%0d, expected 0 320 240", busy_cycles, x, y);
    end
    hide = 1'b0;
  endtask

  task automatic test_buffer_reset();
    bit st;
    do_reset();
    run_seq(3'b110, 1'b1, 1'b0, 9'd0, 8'd0, 9'd96, 8'd220, 9'd96, 8'd220, 8'd220, 1'b0, 1'b0, 1'b1);
`ifdef MOVE_BUFFER_EN
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b1 || chk_x !== 9'd97 || chk_y !== 8'd219) begin
      n_fail++;
      $display("FAIL buffer_start: busy=%0b x=%0d y=%0d, expected 1 97 219", busy, chk_x, chk_y);
    end
`else
    begin
      int busy_cycles;
      busy_cycles = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        if (busy) busy_cycles++;
      end
      n_checks++;
      if (busy_cycles !== 0) begin
        n_fail++;
        $display("FAIL no_buffer_drop: busy_cycles=%0d, expected 0", busy_cycles);
      end
    end
    move = 1'b1; dir = 3'b110;
    wait_start(st);
    move = 1'b0;
`endif
    n_checks++;
    if (chk_req !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_req: chk_req=%0b, expected 1", chk_req);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (chk_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_req: chk_req=%0b, expected 0", chk_req);
    end
    @(negedge clock);
    n_checks++;
    if (x !== 9'd95 || y !== 8'd221 || busy !== 1'b0 || chk_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: x=%0d y=%0d busy=%0b req=%0b, expected 95 221 0 0", x, y, busy, chk_req);
    end
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_move();
    test_oob();
    test_reject_tele();
    test_lift();
    test_hide();
    test_buffer_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
